// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers the raster position from an HSync/VSync pair (both active-low) that
// runs on the same pixel clock. The sync inputs are registered once. Each
// falling edge reloads the matching position counter to its nominal sync
// position. Between edges the counters free-run. Pulse positions and widths
// are checked against nominal timing, and a small FSM declares lock after
// LOCK_FRAMES consecutive clean frames.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset; clears all history
//   hsync_in     HSync, active-low
//   vsync_in     VSync, active-low
//   hpos         recovered horizontal position (0 .. H_TOTAL-1)
//   vpos         recovered vertical position (0 .. V_TOTAL-1)
//   display_on   locked and inside the addressable area (decoded from registers)
//   locked       timing verified
//   hsync_err    one-clock pulse after a horizontal timing violation
//   vsync_err    one-clock pulse after a vertical timing violation
//   frame_start  one-clock pulse in the cycle where (hpos, vpos, locked)
//                becomes (0, 0, 1)
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_ADDR       = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC       = 96,
  parameter int V_ADDR       = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC       = 2,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       locked,
  output logic       hsync_err,
  output logic       vsync_err,
  output logic       frame_start
);

  localparam logic [9:0] H_ADDR_C    = 10'(H_ADDR);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FALL_POS  = 10'(H_SYNC_START);
  localparam logic [9:0] H_RISE_POS  = 10'(H_SYNC_START + H_SYNC);
  localparam logic [9:0] V_ADDR_C    = 10'(V_ADDR);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FALL_POS  = 10'(V_SYNC_START);
  localparam logic [9:0] V_RISE_POS  = 10'(V_SYNC_START + V_SYNC);
  localparam logic [9:0] LOCK_TARGET = 10'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  lock_state_t state;

  logic       hs_q, vs_q;
  logic       hs_fall, hs_rise, vs_fall, vs_rise;
  logic       h_end, v_end, frame_bnd;
  logic [9:0] hpos_pred, vpos_pred, hpos_next, vpos_next;
  logic       h_seen, v_seen, v_fall_in_frame;
  logic       h_viol, v_viol, any_viol;
  logic [9:0] clean_cnt, clean_inc;
  logic       clean_done, locked_next;

  // Edge detection against the registered copy of each sync line.
  assign hs_fall = hs_q & ~hsync_in;
  assign hs_rise = ~hs_q & hsync_in;
  assign vs_fall = vs_q & ~vsync_in;
  assign vs_rise = ~vs_q & vsync_in;

  assign h_end     = (hpos == H_LAST);
  assign v_end     = (vpos == V_LAST);
  assign frame_bnd = h_end & v_end;

  // Free-running prediction; vpos only advances on the last clock of a line.
  assign hpos_pred = h_end ? 10'd0 : hpos + 10'd1;
  assign vpos_pred = !h_end ? vpos : (v_end ? 10'd0 : vpos + 10'd1);

  // A falling edge always reloads, even when it is reported as a violation,
  // so tracking re-aligns on the very clock that sees the edge.
  assign hpos_next = hs_fall ? H_FALL_POS : hpos_pred;
  assign vpos_next = vs_fall ? V_FALL_POS : vpos_pred;

  // Horizontal: early/late fall, missing fall, early/late rise.
  assign h_viol = h_seen &
                  ((hs_fall & (hpos_pred != H_FALL_POS)) |
                   (~hs_fall & (hpos_pred == H_FALL_POS)) |
                   (hs_rise & (hpos_pred != H_RISE_POS)) |
                   (~hsync_in & (hpos_pred == H_RISE_POS)));

  // Vertical: misplaced fall or rise, or a frame closing without any fall.
  // A fall in the boundary cycle itself still belongs to the closing frame.
  assign v_viol = v_seen &
                  ((vs_fall & (vpos_pred != V_FALL_POS)) |
                   (vs_rise & (vpos_pred != V_RISE_POS)) |
                   (frame_bnd & ~(v_fall_in_frame | vs_fall)));

  assign any_viol = h_viol | v_viol;

  // Lock decision; a violation in the boundary cycle spoils the closing frame.
  assign clean_inc   = clean_cnt + 10'd1;
  assign clean_done  = (state == TRACK) & frame_bnd & ~any_viol &
                       (clean_inc >= LOCK_TARGET);
  assign locked_next = clean_done | ((state == LOCKED) & ~any_viol);

  assign display_on = locked & (hpos < H_ADDR_C) & (vpos < V_ADDR_C);

  // Position tracking, edge history and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      hpos            <= 10'd0;
      vpos            <= 10'd0;
      h_seen          <= 1'b0;
      v_seen          <= 1'b0;
      v_fall_in_frame <= 1'b0;
      hsync_err       <= 1'b0;
      vsync_err       <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      hpos      <= hpos_next;
      vpos      <= vpos_next;
      hsync_err <= h_viol;
      vsync_err <= v_viol;
      if (hs_fall) h_seen <= 1'b1;
      if (vs_fall) v_seen <= 1'b1;
      if (frame_bnd)    v_fall_in_frame <= 1'b0;
      else if (vs_fall) v_fall_in_frame <= 1'b1;
      frame_start <= locked_next & (hpos_next == 10'd0) & (vpos_next == 10'd0);
    end
  end

  // Lock FSM with registered locked output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      clean_cnt <= 10'd0;
      locked    <= 1'b0;
    end else begin
      locked <= locked_next;
      case (state)
        SEARCH: begin
          clean_cnt <= 10'd0;
          if (h_seen & v_seen) state <= TRACK;
        end
        TRACK: begin
          if (any_viol) begin
            clean_cnt <= 10'd0;
          end else if (frame_bnd) begin
            if (clean_done) begin
              state     <= LOCKED;
              clean_cnt <= 10'd0;
            end else begin
              clean_cnt <= clean_inc;
            end
          end
        end
        LOCKED: begin
          if (any_viol) begin
            state     <= TRACK;
            clean_cnt <= 10'd0;
          end
        end
        default: begin
          state     <= SEARCH;
          clean_cnt <= 10'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives the decoder from a small raster generator (reduced timing so that
// several frames fit in a short run). Faults are injected into chosen lines,
// and short bursts of random sync glitches are added. Every cycle the DUT
// outputs are compared with a reference model. The model keeps the raster
// position as one flat index into the frame, and the rest of its state is
// plain flags and a counter. Scenario-level expectations (lock latency,
// error counts, reload positions) are checked directly.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HSS = 18;
  localparam int HS  = 3;
  localparam int VA  = 10;
  localparam int VT  = 14;
  localparam int VSS = 11;
  localparam int VS  = 2;
  localparam int LF  = 2;
  localparam int F   = HT * VT;

  logic       clk, rst_n, hsync_in, vsync_in;
  logic [9:0] hpos, vpos;
  logic       display_on, locked, hsync_err, vsync_err, frame_start;

  vga_sync_decoder #(
    .H_ADDR(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC(HS),
    .V_ADDR(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC(VS),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
    .hsync_err(hsync_err), .vsync_err(vsync_err), .frame_start(frame_start)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // generator / stimulus state
  int gp;              // flat generator position within the frame
  bit track_gen;       // compare against generator while the model is locked
  bit noise;           // randomly flip sync samples

  // statistics gathered per step
  int step_idx, lock_step, herr_cnt, verr_cnt, herr_hpos, verr_vpos;
  int disp_cnt, fs_cnt;
  bit saw_unlock;

  // reference model state
  int m_p;             // flat position vpos*HT + hpos
  int m_mode;          // 0 searching, 1 tracking, 2 locked
  int m_clean;
  bit m_hs_prev, m_vs_prev, m_hseen, m_vseen, m_vgot;
  bit e_herr, e_verr;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_p = 0; m_mode = 0; m_clean = 0;
    m_hs_prev = 1'b1; m_vs_prev = 1'b1;
    m_hseen = 1'b0; m_vseen = 1'b0; m_vgot = 1'b0;
    e_herr = 1'b0; e_verr = 1'b0;
  endtask

  task automatic model_edge(input logic hs, input logic vs);
    bit hfall, hrise, vfall, vrise, bnd, err;
    int np, nh, nv;
    hfall = m_hs_prev && !hs;
    hrise = !m_hs_prev && hs;
    vfall = m_vs_prev && !vs;
    vrise = !m_vs_prev && vs;
    np  = (m_p + 1) % F;
    nh  = np % HT;
    nv  = np / HT;
    bnd = (m_p == F - 1);
    e_herr = m_hseen && ((hfall && nh != HSS) || (!hfall && nh == HSS) ||
                         (hrise && nh != HSS + HS) || (!hs && nh == HSS + HS));
    e_verr = m_vseen && ((vfall && nv != VSS) || (vrise && nv != VSS + VS) ||
                         (bnd && !(m_vgot || vfall)));
    err = e_herr || e_verr;
    if (m_mode == 0) begin
      m_clean = 0;
      if (m_hseen && m_vseen) m_mode = 1;
    end else if (m_mode == 1) begin
      if (err) m_clean = 0;
      else if (bnd) begin
        m_clean++;
        if (m_clean >= LF) begin
          m_mode = 2;
          m_clean = 0;
        end
      end
    end else if (err) begin
      m_mode = 1;
      m_clean = 0;
    end
    m_p = (vfall ? VSS : nv) * HT + (hfall ? HSS : nh);
    if (bnd) m_vgot = 1'b0;
    else if (vfall) m_vgot = 1'b1;
    if (hfall) m_hseen = 1'b1;
    if (vfall) m_vseen = 1'b1;
    m_hs_prev = hs;
    m_vs_prev = vs;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    lock_step = -1; herr_cnt = 0; verr_cnt = 0; herr_hpos = -1; verr_vpos = -1;
    disp_cnt = 0; fs_cnt = 0; saw_unlock = 1'b0;
  endtask

  // One clock: drive inputs, let the DUT and model take the edge, compare.
  task automatic step(input logic hs, input logic vs);
    bit e_lock;
    hsync_in = hs;
    vsync_in = vs;
    @(posedge clk);
    model_edge(hs, vs);
    @(negedge clk);
    e_lock = (m_mode == 2);
    chk("hpos", hpos, 10'(m_p % HT));
    chk("vpos", vpos, 10'(m_p / HT));
    chk("locked", 10'(locked), 10'(e_lock));
    chk("display_on", 10'(display_on),
        10'(e_lock && (m_p % HT) < HA && (m_p / HT) < VA));
    chk("hsync_err", 10'(hsync_err), 10'(e_herr));
    chk("vsync_err", 10'(vsync_err), 10'(e_verr));
    chk("frame_start", 10'(frame_start), 10'(e_lock && m_p == 0));
    if (hsync_err === 1'b1) begin
      if (herr_cnt == 0) herr_hpos = int'(hpos);
      herr_cnt++;
    end
    if (vsync_err === 1'b1) begin
      if (verr_cnt == 0) verr_vpos = int'(vpos);
      verr_cnt++;
    end
    if (locked === 1'b0) saw_unlock = 1'b1;
    if (locked === 1'b1 && lock_step < 0) lock_step = step_idx;
    if (display_on === 1'b1) disp_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    step_idx++;
  endtask

  // One generator clock with optional single-line faults.
  task automatic gen_step(input bit no_hs, input bit no_vs, input bit wide_hs,
                          input bit short_line);
    int gh, gv;
    logic hs, vs;
    gh = gp % HT;
    gv = gp / HT;
    hs = !((gh >= HSS) && (gh < HSS + HS + (wide_hs ? 1 : 0)));
    vs = !((gv >= VSS) && (gv < VSS + VS));
    if (no_hs) hs = 1'b1;
    if (no_vs) vs = 1'b1;
    if (noise && $urandom_range(0, 15) == 0) hs = ~hs;
    if (noise && $urandom_range(0, 15) == 0) vs = ~vs;
    step(hs, vs);
    if (track_gen && m_mode == 2) begin
      chk("hpos_vs_gen", hpos, 10'(gh));
      chk("vpos_vs_gen", vpos, 10'(gv));
    end
    gp = (gp + ((short_line && gh == HT - 2) ? 2 : 1)) % F;
  endtask

  task automatic run_clean(input int n);
    track_gen = 1'b1;
    for (int i = 0; i < n; i++) gen_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sync_to_frame();
    for (int i = 0; i < F && gp != 0; i++) gen_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // kind: 0 short line, 1 missing hsync, 2 wide hsync, 3 missing vsync
  task automatic fault_frame(input int kind, input int line);
    bit on;
    clear_stats();
    track_gen = 1'b0;
    for (int j = 0; j < F; j++) begin
      on = ((gp / HT) == line);
      gen_step(kind == 1 && on, kind == 3, kind == 2 && on, kind == 0 && on);
    end
    run_clean(2 * F + 4);
  endtask

  task automatic check_reset_outputs();
    chk("rst_hpos", hpos, 10'd0);
    chk("rst_vpos", vpos, 10'd0);
    chk("rst_locked", 10'(locked), 10'd0);
    chk("rst_display_on", 10'(display_on), 10'd0);
    chk("rst_hsync_err", 10'(hsync_err), 10'd0);
    chk("rst_vsync_err", 10'(vsync_err), 10'd0);
    chk("rst_frame_start", 10'(frame_start), 10'd0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    gp = 0;
    step_idx = 0;
    clear_stats();
  endtask

  // ---------------- directed sequence ----------------
  int line_sel, hh_sel;

  initial begin
    rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    track_gen = 1'b0; noise = 1'b0; gp = 0; step_idx = 0;
    model_reset();
    clear_stats();

    // reset state
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    release_reset();

    // clean lock from reset: lock one clock after the second boundary
    run_clean(2 * F);
    disp_cnt = 0;
    fs_cnt = 0;
    run_clean(F);
    chk_int("lock_latency", lock_step, 2 * F);
    chk_int("display_area", disp_cnt, HA * VA);
    chk_int("frame_start_count", fs_cnt, 1);
    chk_int("clean_hsync_errs", herr_cnt, 0);
    chk_int("clean_vsync_errs", verr_cnt, 0);

    // short line
    sync_to_frame();
    line_sel = $urandom_range(1, VA - 1);
    fault_frame(0, line_sel);
    chk_int("short_herr_count", herr_cnt, 1);
    chk_int("short_reload_hpos", herr_hpos, HSS);
    chk_int("short_unlock", int'(saw_unlock), 1);
    chk_int("short_verr_count", verr_cnt, 0);
    chk("short_relock", 10'(locked), 10'd1);

    // missing hsync for one line
    sync_to_frame();
    line_sel = $urandom_range(0, VT - 1);
    fault_frame(1, line_sel);
    chk_int("nohs_herr_count", herr_cnt, 1);
    chk_int("nohs_freerun_hpos", herr_hpos, HSS);
    chk_int("nohs_unlock", int'(saw_unlock), 1);
    chk("nohs_relock", 10'(locked), 10'd1);

    // widened hsync
    sync_to_frame();
    line_sel = $urandom_range(0, VT - 1);
    fault_frame(2, line_sel);
    chk_int("wide_herr_count", herr_cnt, 2);
    chk_int("wide_first_hpos", herr_hpos, HSS + HS);
    chk_int("wide_unlock", int'(saw_unlock), 1);
    chk("wide_relock", 10'(locked), 10'd1);

    // missing vsync for one frame
    sync_to_frame();
    fault_frame(3, 0);
    chk_int("novs_verr_count", verr_cnt, 1);
    chk_int("novs_vpos_at_err", verr_vpos, 0);
    chk_int("novs_herr_count", herr_cnt, 0);
    chk_int("novs_unlock", int'(saw_unlock), 1);
    chk("novs_relock", 10'(locked), 10'd1);

    // reset in the middle of a frame, then full reacquisition
    sync_to_frame();
    line_sel = $urandom_range(1, VA - 1);
    hh_sel = $urandom_range(0, HT - 1);
    run_clean(line_sel * HT + hh_sel);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    release_reset();
    run_clean(2 * F + 4);
    chk_int("relock_latency", lock_step, 2 * F);

    // random glitches on both sync lines, model-checked every clock
    noise = 1'b1;
    track_gen = 1'b0;
    for (int i = 0; i < 3 * F; i++) gen_step(1'b0, 1'b0, 1'b0, 1'b0);
    noise = 1'b0;
    run_clean(3 * F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers raster position from a 640x480 VGA-style HSync/VSync pair on the pixel clock. It is the receive-side counterpart of the sync generator: it regenerates `hpos`/`vpos`/`display_on` from the sync pulses alone. It also checks pulse positions and widths against nominal timing and reports lock. It is used in loopback self-test and in downstream blocks that only see the sync lines.

## Interface
- `H_ADDR`, 640: addressable pixels per line.
- `H_TOTAL`, 800: clocks per line.
- `H_SYNC_START`, 656: `hpos` value assigned to the first clock in which HSync is sampled low.
- `H_SYNC`, 96: nominal HSync low width, in clocks.
- `V_ADDR`, 480: addressable lines.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC_START`, 490: `vpos` value assigned when VSync is first sampled low.
- `V_SYNC`, 2: nominal VSync low width, in lines.
- `LOCK_FRAMES`, 2: consecutive clean frames required before lock.
- All parameters must be < 1024.
- `clk` in 1: pixel clock, same domain as the sync source. No synchronizer.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hsync_in` in 1: HSync, active-low.
- `vsync_in` in 1: VSync, active-low.
- `hpos` out 10: recovered horizontal position.
- `vpos` out 10: recovered vertical position.
- `display_on` out 1: `locked & hpos<H_ADDR & vpos<V_ADDR`. Combinational from registers.
- `locked` out 1: timing verified.
- `hsync_err` out 1: one-clock pulse on a horizontal timing violation.
- `vsync_err` out 1: one-clock pulse on a vertical timing violation.
- `frame_start` out 1: one-clock pulse, registered; high when `hpos`, `vpos` and `locked` next become 0, 0 and 1.

## Operation
- **Input registers.**
  - `hs_q` and `vs_q` register the sync inputs; both reset to 1.
  - `hs_fall = hs_q & ~hsync_in`; `hs_rise = ~hs_q & hsync_in`. Same pattern for `vs_fall`/`vs_rise`.
- **Prediction.**
  - `hpos_pred` = 0 if `hpos == H_TOTAL-1`, else `hpos+1`.
  - `vpos_pred` = `vpos+1` (wrapping to 0 after `V_TOTAL-1`) only on the cycle where `hpos == H_TOTAL-1`; otherwise `vpos`.
- **Position update.** `hpos <= hs_fall ? H_SYNC_START : hpos_pred`. `vpos <= vs_fall ? V_SYNC_START : vpos_pred`. If both falls occur in the same cycle, both loads apply.
- **Horizontal check.** Active only after the first `hs_fall` (`h_seen`). `hsync_err` fires if any of these holds:
  - `hs_fall` while `hpos_pred != H_SYNC_START`;
  - `hpos_pred == H_SYNC_START` with no `hs_fall` (missing edge);
  - `hs_rise` while `hpos_pred != H_SYNC_START+H_SYNC`;
  - `hpos_pred == H_SYNC_START+H_SYNC` while `hsync_in` is still low.
- **Vertical check.** Active only after the first `vs_fall` (`v_seen`). `vsync_err` fires if any of these holds:
  - `vs_fall` while `vpos_pred != V_SYNC_START`;
  - `vs_rise` while `vpos_pred != V_SYNC_START+V_SYNC`;
  - at the frame boundary, no `vs_fall` occurred in the frame just ended.
  - The frame boundary is the cycle with `hpos == H_TOTAL-1` and `vpos == V_TOTAL-1`.
- **Lock FSM.**
  - SEARCH (`locked`=0): go to TRACK once `h_seen & v_seen`.
  - TRACK (`locked`=0): each error-free frame boundary increments `clean_cnt`; any error clears `clean_cnt`. Go to LOCKED when `clean_cnt` reaches `LOCK_FRAMES`.
  - LOCKED (`locked`=1): any error returns to TRACK with `clean_cnt`=0.
  - An error in the boundary cycle itself counts against the frame being closed.
- **Reset values.** `hpos`=0, `vpos`=0, `locked`=0, `hsync_err`=0, `vsync_err`=0, `frame_start`=0. State SEARCH; `h_seen`, `v_seen` and `clean_cnt` cleared. Reset mid-frame applies immediately and discards all history.

## Timing
- One input register stage. `hpos`/`vpos` update on the clock that samples an edge.
- Against a generator with registered sync outputs and the default parameters, the decoder's (`hpos`, `vpos`, `display_on`) equal the generator's values from 2 clocks earlier.
- `hsync_err`/`vsync_err` are registered and high for the clock after the violating sample.
- `locked` changes one clock after the deciding frame boundary or error.
- The position reload on an edge happens even when that edge is an error, so tracking re-aligns immediately.

## Test plan
- **Clean lock.** Drive from the sync generator (640x480) after both blocks reset.
  - `locked` rises one clock after the second frame boundary following the first `vs_fall`.
  - After lock, `hpos`/`vpos` always equal the generator's values from 2 clocks earlier.
  - Errors stay 0 and `display_on` covers exactly 640x480 per frame.
- **Short line.** One locked line shortened to 799 clocks → `hsync_err` pulses once, `locked` falls, `hpos` reloads 656. Relock after 2 clean frames.
- **Missing HSync.** `hsync_in` held high for one line → `hsync_err` at the predicted 656 position. No reload; free-run continues.
- **Wide HSync.** Pulse widened to 97 clocks → `hsync_err` when `hpos_pred` = 752 with input still low, and again at the late rise.
- **Missing VSync.** VSync omitted in one frame → `vsync_err` at the frame boundary (`vpos` 524→0), `locked` drops.
- **Reset mid-frame.** `rst_n` pulsed low at `vpos`=200 → all outputs 0 immediately. After release, full reacquisition with the same latency as the clean-lock scenario.
